// File: rtl/wave_pkg.sv
// Shared constants and enums for the wave RAM read-port arbiter and its scan engine.
package wave_pkg;

    localparam int DW    = 8;
    localparam int AW    = 9;
    localparam int NSAMP = 2 ** (AW - 1);

    localparam logic [DW-1:0] SAMPLE_MID = 8'h80;

    typedef enum logic {
        OWN_DISP,
        OWN_SCAN
    } owner_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_COMMIT
    } state_e;

endpackage

// File: rtl/wave_ram_read_arbiter_peak_accum.sv
// Running min/max of unsigned samples; clear seeds max low and min high so the first fold wins.
module peak_accum
    import wave_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          clear_i,
    input  logic          en_i,
    input  logic [DW-1:0] sample_i,
    output logic [DW-1:0] run_max_o,
    output logic [DW-1:0] run_min_o
);

    logic [DW-1:0] run_max_q, run_max_d;
    logic [DW-1:0] run_min_q, run_min_d;

    // Strict compares: an equal sample leaves the running extreme untouched.
    always_comb begin
        run_max_d = run_max_q;
        run_min_d = run_min_q;
        if (clear_i) begin
            run_max_d = '0;
            run_min_d = '1;
        end else if (en_i) begin
            if (sample_i > run_max_q) run_max_d = sample_i;
            if (sample_i < run_min_q) run_min_d = sample_i;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            run_max_q <= '0;
            run_min_q <= '1;
        end else begin
            run_max_q <= run_max_d;
            run_min_q <= run_min_d;
        end
    end

    assign run_max_o = run_max_q;
    assign run_min_o = run_min_q;

endmodule

// File: rtl/wave_ram_read_arbiter.sv
// Shares RAM read port b between the wave display (priority during active video)
// and a once-per-frame peak scan of the displayed bank, run only in blanking cycles.
module wave_ram_read_arbiter
    import wave_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          valid,
    input  logic          vsync,
    input  logic          read_index,
    input  logic [AW-1:0] disp_read_address,
    input  logic [DW-1:0] ram_read_value,
    output logic [AW-1:0] ram_read_address,
    output logic          scan_busy,
    output logic          scan_done,
    output logic [DW-1:0] peak_max,
    output logic [DW-1:0] peak_min,
    output logic [DW-1:0] peak_amp
);

    localparam logic [AW-1:0] NSAMP_CNT = AW'(NSAMP);

    state_e        state_q, state_d;
    owner_e        owner_q, owner_d;
    logic          vsync_q;
    logic          bank_q, bank_d;
    logic [7:0]    scan_addr_q, scan_addr_d;
    logic [AW-1:0] issue_cnt_q, issue_cnt_d;
    logic [AW-1:0] rx_cnt_q, rx_cnt_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [DW-1:0] pmax_q, pmax_d;
    logic [DW-1:0] pmin_q, pmin_d;
    logic [DW-1:0] pamp_q, pamp_d;

    logic          issue;
    logic          fold;
    logic          acc_clear;
    logic [DW-1:0] run_max;
    logic [DW-1:0] run_min;

    // Display path is a pure passthrough; the scan only gets the port in blanking.
    assign ram_read_address = (valid || state_q != ST_SCAN) ? disp_read_address
                                                             : {bank_q, scan_addr_q};

    assign issue = (state_q == ST_SCAN) && !valid && (issue_cnt_q < NSAMP_CNT);
    assign fold  = (state_q == ST_SCAN) && (owner_q == OWN_SCAN);

    always_comb begin
        state_d     = state_q;
        owner_d     = issue ? OWN_SCAN : OWN_DISP;
        bank_d      = bank_q;
        scan_addr_d = scan_addr_q;
        issue_cnt_d = issue_cnt_q;
        rx_cnt_d    = rx_cnt_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        pmax_d      = pmax_q;
        pmin_d      = pmin_q;
        pamp_d      = pamp_q;
        acc_clear   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (vsync && !vsync_q) begin
                    bank_d      = read_index;
                    scan_addr_d = '0;
                    issue_cnt_d = '0;
                    rx_cnt_d    = '0;
                    acc_clear   = 1'b1;
                    busy_d      = 1'b1;
                    state_d     = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (read_index != bank_q) begin
                    // Bank flipped under us: drop the partial scan, keep old results.
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    if (issue) begin
                        scan_addr_d = scan_addr_q + 8'd1;
                        issue_cnt_d = issue_cnt_q + AW'(1);
                    end
                    if (fold) begin
                        rx_cnt_d = rx_cnt_q + AW'(1);
                        if (rx_cnt_q == NSAMP_CNT - AW'(1)) state_d = ST_COMMIT;
                    end
                end
            end
            ST_COMMIT: begin
                pmax_d  = run_max;
                pmin_d  = run_min;
                pamp_d  = run_max - run_min;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            owner_q     <= OWN_DISP;
            vsync_q     <= 1'b0;
            bank_q      <= 1'b0;
            scan_addr_q <= '0;
            issue_cnt_q <= '0;
            rx_cnt_q    <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pmax_q      <= SAMPLE_MID;
            pmin_q      <= SAMPLE_MID;
            pamp_q      <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            vsync_q     <= vsync;
            bank_q      <= bank_d;
            scan_addr_q <= scan_addr_d;
            issue_cnt_q <= issue_cnt_d;
            rx_cnt_q    <= rx_cnt_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pmax_q      <= pmax_d;
            pmin_q      <= pmin_d;
            pamp_q      <= pamp_d;
        end
    end

    peak_accum u_accum (
        .clk       (clk),
        .reset     (reset),
        .clear_i   (acc_clear),
        .en_i      (fold),
        .sample_i  (ram_read_value),
        .run_max_o (run_max),
        .run_min_o (run_min)
    );

    assign scan_busy = busy_q;
    assign scan_done = done_q;
    assign peak_max  = pmax_q;
    assign peak_min  = pmin_q;
    assign peak_amp  = pamp_q;

endmodule

// File: doc/wave_ram_read_arbiter.md
Name: wave_ram_read_arbiter

Overview:
- Shares the single read port (port b) of the 512x8 sample RAM between the wave display pixel pipeline and an internal peak-scan engine.
- Once per frame, the scan engine walks the 256 samples of the currently displayed bank and reports min, max and peak-to-peak amplitude for a level meter / song-status overlay.
- The display always wins the port during active video; the scanner uses only blanking cycles.
- Sits between wave_display, ram_1w2r and the overlay logic in the wave display top level.

Parameters:
- DW, 8, sample width (unsigned offset-binary, midscale 8'h80)
- AW, 9, RAM address width (MSB = bank select)
- NSAMP, 256, samples per bank (2**(AW-1))

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high
- valid  input  1  display active-video flag (display owns port when high)
- vsync  input  1  frame sync; the scan starts on its rising edge
- read_index  input  1  bank currently shown by the display (from wave_capture)
- disp_read_address  input  AW  address requested by wave_display
- ram_read_value  input  DW  RAM port-b data, 1-cycle read latency
- ram_read_address  output  AW  address driven to RAM port b
- scan_busy  output  1  scan in progress
- scan_done  output  1  one-cycle pulse when new results are committed
- peak_max  output  DW  largest sample of the last completed scan
- peak_min  output  DW  smallest sample of the last completed scan
- peak_amp  output  DW  peak_max - peak_min (unsigned, never negative)

Behaviour:
- Reset values: scan_busy=0, scan_done=0, peak_max=8'h80, peak_min=8'h80, peak_amp=0, FSM=IDLE, owner_q=DISP. Reset mid-scan discards partial results.
- Port mux (combinational): ram_read_address = (valid || state!=SCAN) ? disp_read_address : {bank_q, scan_addr}.
- owner_q registers who drove the address each cycle (SCAN iff the scan address was driven). Data on ram_read_value at cycle t+1 belongs to owner_q. The display path is pure passthrough with zero added latency.
- FSM states:
  - IDLE: on vsync rising edge (vsync_q=0, vsync=1), latch bank_q=read_index, scan_addr=0, issue_cnt=0, rx_cnt=0, run_max=8'h00, run_min=8'hFF, then go to SCAN and set scan_busy=1.
  - SCAN: each cycle with valid=0 and issue_cnt<NSAMP, drive the scan address, then increment scan_addr and issue_cnt. Each cycle with owner_q=SCAN, fold ram_read_value into run_max/run_min and increment rx_cnt. When rx_cnt reaches NSAMP (the last fold), go to COMMIT.
  - COMMIT (1 cycle): peak_max<=run_max, peak_min<=run_min, peak_amp<=run_max-run_min, scan_done=1, scan_busy=0, then go to IDLE.
- Preemption: valid rising mid-scan stalls issue. Any read already in flight still lands next cycle and is folded. No address is skipped or duplicated.
- Bank change: if read_index != bank_q while in SCAN, abort. Go to IDLE without committing (outputs keep previous values) and wait for the next vsync edge.
- vsync edge while in SCAN or COMMIT is ignored; no restart.
- scan_addr wraps within 8 bits; issue_cnt/rx_cnt are AW bits wide to hold NSAMP.
- Min/max compares are unsigned. Equal samples leave run_max/run_min unchanged.
- Minimum scan duration is NSAMP+2 cycles with no display activity. The scan completes across any number of blanking gaps.

Decomposition:
- Shared package wave_pkg holds: DW, AW, NSAMP, SAMPLE_MID=8'h80, the owner enum {OWN_DISP, OWN_SCAN}, and the FSM state enum {ST_IDLE, ST_SCAN, ST_COMMIT}.
- One natural sub-module, peak_accum: running min/max with clear and enable, folding one sample per enabled cycle. The arbiter FSM, mux and owner tracking stay in the top.

Test Plan:
- Reset, then idle with no vsync -> peak_max=peak_min=8'h80, peak_amp=0, scan_busy=0, ram_read_address equals disp_read_address.
- Bank 1 filled with ramp 0..255, read_index=1, valid held 0, vsync pulse -> scan_done exactly 258 cycles after the edge; peak_max=8'hFF, peak_min=8'h00, peak_amp=8'hFF; scan addresses 256..511 seen in order.
- Same bank, valid toggling 3 cycles high / 2 low -> identical results; whenever valid=1, ram_read_address tracks disp_read_address; each address 256..511 is issued exactly once.
- Bank 0 constant 8'h80 except addr 37=8'h20 and addr 200=8'hE0 -> peak_min=8'h20, peak_max=8'hE0, peak_amp=8'hC0.
- read_index toggles after 100 samples -> no scan_done; outputs keep the prior scan's values; the next vsync edge scans the new bank.
- reset asserted at sample 150 -> next cycle scan_busy=0 and outputs return to reset values; the following vsync edge produces a full correct scan.
